// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID boundary: state encoding of the skid
// register and the width/NOP defaults used by the fetch and decode stages.
package if_id_pkg;

    localparam int          PC_W_DEF      = 8;
    localparam int          INSTR_W_DEF   = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // EMPTY: no beat held, BUSY: main slot only, FULL: main and skid slots
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer. in_ready comes straight
// from a flop, so decode back-pressure never reaches fetch combinationally;
// the skid slot absorbs the one beat that is in flight when out_ready drops.
// The skid slot is valid exactly when the state is FULL, so it carries no
// separate valid flop. flush kills everything, including a same-cycle accept.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int unsigned          PC_W      = PC_W_DEF,
    parameter int unsigned          INSTR_W   = INSTR_W_DEF,
    parameter int unsigned          PC_OFFSET = 1,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam logic [PC_W-1:0] PC_OFF_C = PC_W'(PC_OFFSET);

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 in_ready_r;
    logic                 in_ready_nxt_s;
    logic                 main_valid_r;
    logic                 main_valid_nxt_s;
    logic [PC_W-1:0]      main_pc_r;
    logic [PC_W-1:0]      main_pc_nxt_s;
    logic [INSTR_W-1:0]   main_instr_r;
    logic [INSTR_W-1:0]   main_instr_nxt_s;
    logic [PC_W-1:0]      skid_pc_r;
    logic [PC_W-1:0]      skid_pc_nxt_s;
    logic [INSTR_W-1:0]   skid_instr_r;
    logic [INSTR_W-1:0]   skid_instr_nxt_s;
    logic                 accept_s;
    logic                 drain_s;
    logic [PC_W-1:0]      cap_pc_s;

    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = main_valid_r & out_ready;
    // PC adjustment wraps silently modulo 2^PC_W
    assign cap_pc_s = in_pc - PC_OFF_C;

    // Next-state and next-slot contents; flush overrides every handshake
    always_comb begin
        state_nxt_s      = state_r;
        main_pc_nxt_s    = main_pc_r;
        main_instr_nxt_s = main_instr_r;
        skid_pc_nxt_s    = skid_pc_r;
        skid_instr_nxt_s = skid_instr_r;

        if (flush) begin
            state_nxt_s      = EMPTY;
            main_instr_nxt_s = NOP_INSTR;
            skid_pc_nxt_s    = {PC_W{1'b0}};
            skid_instr_nxt_s = NOP_INSTR;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s      = BUSY;
                        main_pc_nxt_s    = cap_pc_s;
                        main_instr_nxt_s = in_instr;
                    end else begin
                        state_nxt_s      = EMPTY;
                    end
                end
                BUSY: begin
                    if (accept_s && drain_s) begin
                        state_nxt_s      = BUSY;
                        main_pc_nxt_s    = cap_pc_s;
                        main_instr_nxt_s = in_instr;
                    end else if (accept_s) begin
                        state_nxt_s      = FULL;
                        skid_pc_nxt_s    = cap_pc_s;
                        skid_instr_nxt_s = in_instr;
                    end else if (drain_s) begin
                        state_nxt_s      = EMPTY;
                        main_instr_nxt_s = NOP_INSTR;
                    end else begin
                        state_nxt_s      = BUSY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can move us
                    if (drain_s) begin
                        state_nxt_s      = BUSY;
                        main_pc_nxt_s    = skid_pc_r;
                        main_instr_nxt_s = skid_instr_r;
                        skid_pc_nxt_s    = {PC_W{1'b0}};
                        skid_instr_nxt_s = NOP_INSTR;
                    end else begin
                        state_nxt_s      = FULL;
                    end
                end
                default: begin
                    state_nxt_s      = EMPTY;
                    main_instr_nxt_s = NOP_INSTR;
                    skid_pc_nxt_s    = {PC_W{1'b0}};
                    skid_instr_nxt_s = NOP_INSTR;
                end
            endcase
        end

        main_valid_nxt_s = (state_nxt_s != EMPTY);
        in_ready_nxt_s   = (state_nxt_s != FULL);
    end

    // State, handshake flops and both data slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= EMPTY;
            in_ready_r   <= 1'b1;
            main_valid_r <= 1'b0;
            main_pc_r    <= {PC_W{1'b0}};
            main_instr_r <= NOP_INSTR;
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= NOP_INSTR;
        end else begin
            state_r      <= state_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            main_valid_r <= main_valid_nxt_s;
            main_pc_r    <= main_pc_nxt_s;
            main_instr_r <= main_instr_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
            skid_instr_r <= skid_instr_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_pc    = main_pc_r;
    assign out_instr = main_instr_r;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed plus randomized bench for if_id_skid_reg. The reference is a
// 2-deep FIFO of adjusted beats whose acceptance is decided by the FIFO
// occupancy after the previous edge.
module tb_if_id_skid_reg;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;

    logic        flush2;
    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] in_pc2;
    logic [31:0] in_instr2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_pc2;
    logic [31:0] out_instr2;

    int          errors = 0;
    int          checks = 0;
    beat_t       q[$];
    logic [7:0]  last_pc;
    bit          last_accept;

    if_id_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    if_id_skid_reg #(.PC_W(16), .INSTR_W(32), .PC_OFFSET(4), .NOP_INSTR(32'h0000_0013)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_pc(in_pc2), .in_instr(in_instr2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_pc(out_pc2), .out_instr(out_instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        chk({tag, ".out_pc"},    32'(out_pc),    32'((q.size() > 0) ? q[0].pc : last_pc));
        chk({tag, ".out_instr"}, out_instr,      (q.size() > 0) ? q[0].instr : 32'h0000_0000);
    endtask

    // One clock: update the FIFO model from the inputs seen at the edge, then check
    task automatic cycle(input string tag);
        bit    rdy;
        beat_t b;
        @(posedge clk);
        rdy = (q.size() < 2);
        last_accept = in_valid && rdy;
        if (flush) begin
            q.delete();
        end else begin
            if ((q.size() > 0) && out_ready) void'(q.pop_front());
            if (last_accept) begin
                b.pc    = in_pc - 8'd1;
                b.instr = in_instr;
                q.push_back(b);
            end
        end
        if (q.size() > 0) last_pc = q[0].pc;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_pc = 8'h05; in_instr = 32'hCAFE_F00D;
        out_ready = 1'b1;
        flush2 = 1'b0; in_valid2 = 1'b0; in_pc2 = 16'h0000; in_instr2 = 32'h1234_5678;
        out_ready2 = 1'b1;
        q.delete(); last_pc = 8'h00; last_accept = 1'b0;

        // Reset held across edges with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_pc",    32'(out_pc),    32'd0);
        chk("rst.out_instr", out_instr,      32'h0000_0000);
        chk("rst.out_instr16", out_instr2,   32'h0000_0013);
        rst_n = 1'b1;

        // First beat after release
        in_valid = 1'b1; in_pc = 8'h05; in_instr = 32'hDEAD_BEEF; out_ready = 1'b0;
        cycle("first");
        chk("first.pc",    32'(out_pc),    32'h04);
        chk("first.instr", out_instr,      32'hDEAD_BEEF);
        chk("first.valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle("drain0");

        // PC wrap on both widths
        in_valid = 1'b1; in_pc = 8'h00; in_instr = 32'h0000_1111;
        in_valid2 = 1'b1; in_pc2 = 16'h0002;
        cycle("wrap");
        chk("wrap.pc8",     32'(out_pc),     32'h0000_00FF);
        chk("wrap.pc16",    32'(out_pc2),    32'h0000_FFFE);
        chk("wrap.valid16", 32'(out_valid2), 32'd1);
        chk("wrap.instr16", out_instr2,      32'h1234_5678);
        in_valid = 1'b0; in_valid2 = 1'b0;
        cycle("drain1");

        // Streaming 16 beats with decode always ready
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_pc = 8'(8'h20 + i); in_instr = $urandom;
            cycle("stream");
            chk("stream.in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        cycle("stream_tail");

        // Stall: out_ready low for 3 cycles while fetch keeps offering
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'h40; in_instr = $urandom;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            if (last_accept) begin in_pc = in_pc + 8'd1; in_instr = $urandom; end
        end
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        chk("stall.pc",       32'(out_pc),   32'h3F);
        out_ready = 1'b1;
        cycle("resume0");
        for (int i = 0; i < 3; i++) begin
            if (last_accept) begin in_pc = in_pc + 8'd1; in_instr = $urandom; end
            cycle("resume");
        end
        in_valid = 1'b0;
        repeat (3) cycle("idle");

        // Flush while FULL with an incoming beat
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'h60; in_instr = 32'hAAAA_0001;
        cycle("fill0");
        in_pc = 8'h61; in_instr = 32'hAAAA_0002;
        cycle("fill1");
        chk("fill.in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1; in_pc = 8'h62; in_instr = 32'hAAAA_0003;
        cycle("flush");
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.ready", 32'(in_ready),  32'd1);
        chk("flush.instr", out_instr,      32'h0000_0000);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) cycle("post_flush");

        // Randomized traffic obeying the upstream hold rule
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || last_accept) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = 8'($urandom);
                in_instr = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        // Asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'h70; in_instr = 32'hBBBB_0001;
        cycle("rfill0");
        in_pc = 8'h71; in_instr = 32'hBBBB_0002;
        cycle("rfill1");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready",  32'(in_ready),  32'd1);
        chk("arst.out_pc",    32'(out_pc),    32'd0);
        chk("arst.out_instr", out_instr,      32'h0000_0000);
        q.delete(); last_pc = 8'h00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
